alu_cmd_issuer: RTL and testbench

//  Front-end that assembles 3-word ALU command frames (opcode, A, B) from a valid/ready byte stream,

---
 rtl/alu_cmd_pkg.sv | 35 +++
 rtl/alu_timeout_cnt.sv | 47 ++++
 rtl/alu_cmd_issuer.sv | 160 ++++++++++++++++
 tb/tb_alu_cmd_issuer.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_cmd_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : alu_cmd_pkg                                             |
// | Brief  : Shared types and constants for the ALU command issuer:  |
// |          FSM state encoding, command frame length and the ALU    |
// |          function codes that the ALU unit-enable decoder uses.   |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
package alu_cmd_pkg;

  // Issuer FSM states; IDLE must stay at zero so the reset state reads as all-zero.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GET_A = 3'd1,
    ST_GET_B = 3'd2,
    ST_ISSUE = 3'd3,
    ST_WAIT  = 3'd4,
    ST_RESP  = 3'd5
  } state_t;

  // Words per command frame: opcode, operand A, operand B.
  localparam int c_frame_words = 3;

  // ALU function codes as decoded by the ALU unit-enable decoder.
  localparam logic [3:0] c_alu_fun_add = 4'h0;
  localparam logic [3:0] c_alu_fun_sub = 4'h1;
  localparam logic [3:0] c_alu_fun_mul = 4'h2;
  localparam logic [3:0] c_alu_fun_div = 4'h3;
  localparam logic [3:0] c_alu_fun_and = 4'h4;
  localparam logic [3:0] c_alu_fun_or  = 4'h5;
  localparam logic [3:0] c_alu_fun_xor = 4'h6;
  localparam logic [3:0] c_alu_fun_cmp = 4'h7;

endpackage
`default_nettype wire

// File: rtl/alu_timeout_cnt.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : alu_timeout_cnt                                         |
// | Brief  : WAIT-state watchdog. Cleared on entry to WAIT, counts   |
// |          while enabled, flags expiry on the TIMEOUT_CYCLES-th    |
// |          enabled cycle and then saturates.                       |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module alu_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int c_cnt_w = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

  logic [c_cnt_w-1:0] cnt_q, cnt_d;

  // Next count: clear has priority, otherwise advance while enabled, holding at the last value.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != c_last)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The count equals cycles already spent in WAIT, so c_last marks the final allowed cycle.
  assign expired_o = en_i && (cnt_q == c_last);

endmodule
`default_nettype wire

// File: rtl/alu_cmd_issuer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : alu_cmd_issuer                                          |
// | Brief  : Assembles opcode/A/B frames from a valid/ready byte     |
// |          stream, issues a one-cycle ALU_EN, waits for the ALU    |
// |          result and returns it on a valid/ready response port.   |
// | Config : ALU_TIMEOUT_EN - abort WAIT after TIMEOUT_CYCLES with   |
// |          RES_ERR=1, RES_DATA=0 (default build: wait forever).    |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module alu_cmd_issuer
  import alu_cmd_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int OUT_WIDTH      = 16,
  parameter int ALU_FUN_WIDTH  = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [DATA_WIDTH-1:0]    CMD_DATA,
  input  logic                     CMD_VALID,
  output logic                     CMD_READY,
  output logic [DATA_WIDTH-1:0]    ALU_A,
  output logic [DATA_WIDTH-1:0]    ALU_B,
  output logic [ALU_FUN_WIDTH-1:0] ALU_FUN,
  output logic                     ALU_EN,
  input  logic [OUT_WIDTH-1:0]     ALU_OUT,
  input  logic                     ALU_OUT_VALID,
  output logic [OUT_WIDTH-1:0]     RES_DATA,
  output logic                     RES_VALID,
  input  logic                     RES_READY,
  output logic                     RES_ERR,
  output logic                     BUSY
);

  state_t                   state_q, state_d;
  logic [ALU_FUN_WIDTH-1:0] fun_q, fun_d;
  logic [DATA_WIDTH-1:0]    a_q, a_d;
  logic [DATA_WIDTH-1:0]    b_q, b_d;
  logic [OUT_WIDTH-1:0]     res_data_q, res_data_d;
  logic                     res_err_q, res_err_d;
  // Low during reset and for the first cycle after it, so CMD_READY reads 0 while in reset.
  logic                     live_q;

  logic w_accepting;
  logic w_beat;
  logic w_timeout_expired;
  logic w_tmo_clr;
  logic w_tmo_en;

  assign w_accepting = (state_q == ST_IDLE) || (state_q == ST_GET_A) || (state_q == ST_GET_B);
  assign CMD_READY   = live_q && w_accepting;
  assign w_beat      = CMD_VALID && CMD_READY;

  // Counter starts from zero on the cycle that enters WAIT, which is always the ISSUE cycle.
  assign w_tmo_clr = (state_q == ST_ISSUE);
  assign w_tmo_en  = (state_q == ST_WAIT);

`ifdef ALU_TIMEOUT_EN
  alu_timeout_cnt #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk_i     (CLK),
    .rst_ni    (RST),
    .clr_i     (w_tmo_clr),
    .en_i      (w_tmo_en),
    .expired_o (w_timeout_expired)
  );
`else
  logic w_unused_timeout;
  assign w_unused_timeout  = (TIMEOUT_CYCLES > 0) ^ w_tmo_clr ^ w_tmo_en;
  assign w_timeout_expired = 1'b0;
`endif

  // Next-state and datapath capture; every register holds unless its state acts on it.
  always_comb begin
    state_d    = state_q;
    fun_d      = fun_q;
    a_d        = a_q;
    b_d        = b_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    case (state_q)
      ST_IDLE: begin
        if (w_beat) begin
          fun_d   = CMD_DATA[ALU_FUN_WIDTH-1:0];
          state_d = ST_GET_A;
        end
      end
      ST_GET_A: begin
        if (w_beat) begin
          a_d     = CMD_DATA;
          state_d = ST_GET_B;
        end
      end
      ST_GET_B: begin
        if (w_beat) begin
          b_d     = CMD_DATA;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A real result on the expiry cycle takes precedence over the abort.
        if (ALU_OUT_VALID) begin
          res_data_d = ALU_OUT;
          res_err_d  = 1'b0;
          state_d    = ST_RESP;
        end else if (w_timeout_expired) begin
          res_data_d = '0;
          res_err_d  = 1'b1;
          state_d    = ST_RESP;
        end
      end
      ST_RESP: begin
        if (RES_READY) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial frame or outstanding request.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= ST_IDLE;
      fun_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
      live_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fun_q      <= fun_d;
      a_q        <= a_d;
      b_q        <= b_d;
      res_data_q <= res_data_d;
      res_err_q  <= res_err_d;
      live_q     <= 1'b1;
    end
  end

  assign ALU_FUN   = fun_q;
  assign ALU_A     = a_q;
  assign ALU_B     = b_q;
  assign ALU_EN    = (state_q == ST_ISSUE);
  assign RES_VALID = (state_q == ST_RESP);
  assign RES_DATA  = res_data_q;
  assign RES_ERR   = res_err_q;
  assign BUSY      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_issuer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : tb_alu_cmd_issuer                                       |
// | Brief  : Self-checking bench for alu_cmd_issuer. Plays the       |
// |          command source, the ALU and the result consumer; the    |
// |          expected result comes from a behavioural ALU model      |
// |          applied to the frame words that were sent.              |
// | Config : ALU_TIMEOUT_EN selects the timeout checks.              |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module tb_alu_cmd_issuer;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  CMD_DATA;
  logic        CMD_VALID;
  logic        CMD_READY;
  logic [7:0]  ALU_A;
  logic [7:0]  ALU_B;
  logic [3:0]  ALU_FUN;
  logic        ALU_EN;
  logic [15:0] ALU_OUT;
  logic        ALU_OUT_VALID;
  logic [15:0] RES_DATA;
  logic        RES_VALID;
  logic        RES_READY;
  logic        RES_ERR;
  logic        BUSY;

  int n_checks = 0;
  int n_fail   = 0;
  int en_count = 0;

  alu_cmd_issuer #(
    .DATA_WIDTH     (8),
    .OUT_WIDTH      (16),
    .ALU_FUN_WIDTH  (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .CMD_DATA      (CMD_DATA),
    .CMD_VALID     (CMD_VALID),
    .CMD_READY     (CMD_READY),
    .ALU_A         (ALU_A),
    .ALU_B         (ALU_B),
    .ALU_FUN       (ALU_FUN),
    .ALU_EN        (ALU_EN),
    .ALU_OUT       (ALU_OUT),
    .ALU_OUT_VALID (ALU_OUT_VALID),
    .RES_DATA      (RES_DATA),
    .RES_VALID     (RES_VALID),
    .RES_READY     (RES_READY),
    .RES_ERR       (RES_ERR),
    .BUSY          (BUSY)
  );

  always #5 CLK = ~CLK;

  // Total number of cycles in which the issue strobe was seen high.
  always @(posedge CLK) begin
    if (ALU_EN) en_count <= en_count + 1;
  end

  // Behavioural ALU: what the ALU returns for a given function and operands.
  function automatic logic [15:0] alu_ref(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
    case (f)
      4'h0:    return 16'(a) + 16'(b);
      4'h1:    return 16'(a) - 16'(b);
      4'h2:    return 16'(a) * 16'(b);
      4'h4:    return {8'h00, a & b};
      4'h5:    return {8'h00, a | b};
      4'h6:    return {8'h00, a ^ b};
      default: return {a, b} ^ {12'h000, f};
    endcase
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Offer one command word after 'gap' idle cycles; with noise, a bogus ALU result is driven in the gap.
  task automatic send_word(input logic [7:0] d, input int gap, input bit noise);
    int guard;
    for (int i = 0; i < gap; i++) begin
      CMD_VALID = 1'b0;
      if (noise) begin
        ALU_OUT_VALID = 1'b1;
        ALU_OUT       = 16'hBEEF;
      end
      tick();
      if (noise) begin
        chk1("noise_no_res_valid", RES_VALID, 1'b0);
        chk1("noise_still_ready", CMD_READY, 1'b1);
      end
    end
    ALU_OUT_VALID = 1'b0;
    ALU_OUT       = 16'h0000;
    CMD_VALID     = 1'b1;
    CMD_DATA      = d;
    guard = 0;
    while (CMD_READY !== 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    chk1("cmd_ready_for_beat", CMD_READY, 1'b1);
    tick();
    CMD_VALID = 1'b0;
    CMD_DATA  = 8'($urandom);
  endtask

  // One complete command: send frame, answer as the ALU after 'dly' WAIT cycles, hold the response 'hold' cycles.
  task automatic run_frame(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                           input int gap, input int dly, input int hold, input bit noise);
    logic [15:0] exp;
    int          en_before;
    exp       = alu_ref(op[3:0], a, b);
    en_before = en_count;
    send_word(op, gap, noise);
    send_word(a, gap, 1'b0);
    send_word(b, gap, noise);
    // First cycle after the last beat: the issue cycle.
    chk1("issue_alu_en", ALU_EN, 1'b1);
    chk16("issue_alu_fun", 16'(ALU_FUN), 16'(op[3:0]));
    chk16("issue_alu_a", 16'(ALU_A), 16'(a));
    chk16("issue_alu_b", 16'(ALU_B), 16'(b));
    chk1("issue_cmd_ready", CMD_READY, 1'b0);
    tick();
    chk1("wait_alu_en_low", ALU_EN, 1'b0);
    chk16("single_en_pulse", 16'(en_count - en_before), 16'd1);
    for (int i = 0; i < dly; i++) begin
      chk1("wait_no_res_valid", RES_VALID, 1'b0);
      tick();
    end
    ALU_OUT_VALID = 1'b1;
    ALU_OUT       = alu_ref(ALU_FUN, ALU_A, ALU_B);
    tick();
    ALU_OUT_VALID = 1'b0;
    ALU_OUT       = 16'h0000;
    chk1("resp_valid", RES_VALID, 1'b1);
    chk16("resp_data", RES_DATA, exp);
    chk1("resp_err", RES_ERR, 1'b0);
    chk1("resp_busy", BUSY, 1'b1);
    for (int i = 0; i < hold; i++) begin
      RES_READY = 1'b0;
      tick();
      chk1("hold_valid", RES_VALID, 1'b1);
      chk16("hold_data", RES_DATA, exp);
      chk1("hold_cmd_ready", CMD_READY, 1'b0);
      chk1("hold_busy", BUSY, 1'b1);
      chk16("hold_alu_a", 16'(ALU_A), 16'(a));
    end
    RES_READY = 1'b1;
    tick();
    RES_READY = 1'b0;
    chk1("after_hs_valid", RES_VALID, 1'b0);
    chk1("after_hs_busy", BUSY, 1'b0);
    chk1("after_hs_ready", CMD_READY, 1'b1);
    chk16("frame_en_total", 16'(en_count - en_before), 16'd1);
  endtask

  initial begin
    int bad;
    int n;
    RST           = 1'b0;
    CMD_DATA      = 8'h00;
    CMD_VALID     = 1'b0;
    ALU_OUT       = 16'h0000;
    ALU_OUT_VALID = 1'b0;
    RES_READY     = 1'b0;
    repeat (2) @(posedge CLK);
    #1;

    // Reset state: everything reads zero.
    chk1("rst_cmd_ready", CMD_READY, 1'b0);
    chk1("rst_busy", BUSY, 1'b0);
    chk1("rst_alu_en", ALU_EN, 1'b0);
    chk1("rst_res_valid", RES_VALID, 1'b0);
    chk1("rst_res_err", RES_ERR, 1'b0);
    chk16("rst_res_data", RES_DATA, 16'h0000);
    chk16("rst_alu_fun", 16'(ALU_FUN), 16'h0000);
    chk16("rst_alu_a", 16'(ALU_A), 16'h0000);
    chk16("rst_alu_b", 16'(ALU_B), 16'h0000);
    RST = 1'b1;
    tick();
    chk1("ready_after_rst", CMD_READY, 1'b1);

    // Back-to-back frame with immediate ALU answer and immediate consumer.
    run_frame(8'h00, 8'h12, 8'h34, 0, 0, 0, 1'b0);
    // Same frame, consumer stalls five cycles.
    run_frame(8'h00, 8'h12, 8'h34, 0, 0, 5, 1'b0);
    // Upper opcode bits ignored, two-cycle gaps between words.
    run_frame(8'hF5, 8'h07, 8'h03, 2, 0, 0, 1'b0);

    // Reset after the second beat aborts the frame asynchronously.
    send_word(8'h03, 0, 1'b0);
    send_word(8'h11, 0, 1'b0);
    #2 RST = 1'b0;
    #1;
    chk16("abort_alu_fun", 16'(ALU_FUN), 16'h0000);
    chk16("abort_alu_a", 16'(ALU_A), 16'h0000);
    chk1("abort_busy", BUSY, 1'b0);
    chk1("abort_cmd_ready", CMD_READY, 1'b0);
    chk1("abort_res_valid", RES_VALID, 1'b0);
    tick();
    RST = 1'b1;
    tick();
    run_frame(8'h01, 8'hAA, 8'h55, 0, 1, 1, 1'b0);

    // Stray ALU results in IDLE and GET_B are ignored.
    run_frame(8'h06, 8'h5A, 8'hC3, 2, 0, 0, 1'b1);

    // Randomized frames, gaps, ALU latency and consumer back-pressure.
    for (int i = 0; i < 24; i++) begin
      run_frame(8'($urandom), 8'($urandom), 8'($urandom),
                int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

`ifdef ALU_TIMEOUT_EN
    // Result on the last allowed WAIT cycle still wins over the timeout.
    send_word(8'h00, 0, 1'b0);
    send_word(8'h21, 0, 1'b0);
    send_word(8'h43, 0, 1'b0);
    tick();
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      if (RES_VALID !== 1'b0) bad++;
      tick();
    end
    chk16("no_early_timeout", 16'(bad), 16'd0);
    ALU_OUT_VALID = 1'b1;
    ALU_OUT       = alu_ref(ALU_FUN, ALU_A, ALU_B);
    tick();
    ALU_OUT_VALID = 1'b0;
    chk1("expiry_win_valid", RES_VALID, 1'b1);
    chk1("expiry_win_err", RES_ERR, 1'b0);
    chk16("expiry_win_data", RES_DATA, 16'h0064);
    RES_READY = 1'b1;
    tick();
    RES_READY = 1'b0;

    // Silent ALU: abort after 16 WAIT cycles.
    send_word(8'h02, 0, 1'b0);
    send_word(8'h0F, 0, 1'b0);
    send_word(8'h0E, 0, 1'b0);
    tick();
    n = 0;
    while (RES_VALID !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk16("timeout_wait_cycles", 16'(n), 16'd16);
    chk1("timeout_valid", RES_VALID, 1'b1);
    chk1("timeout_err", RES_ERR, 1'b1);
    chk16("timeout_data", RES_DATA, 16'h0000);
    RES_READY = 1'b1;
    tick();
    RES_READY = 1'b0;
    chk1("timeout_back_idle", BUSY, 1'b0);
    run_frame(8'h00, 8'h01, 8'h02, 0, 0, 0, 1'b0);
`else
    // Silent ALU: the issuer keeps waiting.
    send_word(8'h02, 0, 1'b0);
    send_word(8'h0F, 0, 1'b0);
    send_word(8'h0E, 0, 1'b0);
    tick();
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (BUSY !== 1'b1 || RES_VALID !== 1'b0 || RES_ERR !== 1'b0) bad++;
      tick();
    end
    chk16("wait_forever_violations", 16'(bad), 16'd0);
    chk1("wait_forever_busy", BUSY, 1'b1);
    RST = 1'b0;
    tick();
    RST = 1'b1;
    tick();
    chk1("recover_busy", BUSY, 1'b0);
    run_frame(8'h00, 8'h01, 8'h02, 0, 0, 0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
